// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner tag and the registered bus request.
package mem_arb_pkg;
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_BE_W   = PKG_DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;

  // Sized by the package widths; the top-level ADDR_W/DATA_W must match these.
  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic                  we;
    logic [PKG_DATA_W-1:0] wdata;
    logic [PKG_BE_W-1:0]   be;
  } mem_bus_req_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and memory-side bus signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              stall;
  logic              bus_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [DATA_W-1:0] bus_wdata;
  logic [BE_W-1:0]   bus_be;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    input  bus_ready, bus_rdata, bus_err,
    output if_done, if_rdata, d_done, d_rdata, err, stall,
    output bus_valid, bus_addr, bus_we, bus_wdata, bus_be
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    output bus_ready, bus_rdata, bus_err,
    input  if_done, if_rdata, d_done, d_rdata, err, stall,
    input  bus_valid, bus_addr, bus_we, bus_wdata, bus_be
  );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Clearable busy-cycle counter; expire is high in the cycle whose edge brings the count to TIMEOUT_CYCLES.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset || clr)                          cnt <= '0;
    else if (en && cnt != CW'(TIMEOUT_CYCLES))  cnt <= cnt + 1'b1;
  end

  // Firing one count early keeps bus_valid up for exactly TIMEOUT_CYCLES cycles.
  assign expire = en && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: IDLE -> BUSY -> RESP, with data priority,
// a fetch anti-starvation streak limit and a watchdog that turns a hung bus into an error.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = PKG_ADDR_W,
  parameter int DATA_W          = PKG_DATA_W,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.master  port_if
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  arb_state_t        state, state_nxt;
  arb_owner_t        owner;
  logic [SW-1:0]     streak;
  mem_bus_req_t      bus_q, grant_req;
  logic              bus_valid_q;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              fetch_wins, grant_data, grant_fetch, handshake, wd_en, expire;

  always_comb begin
    fetch_wins  = port_if.if_req && (streak == SW'(MAX_DATA_STREAK));
    grant_data  = (state == IDLE) && port_if.d_req && !fetch_wins;
    grant_fetch = (state == IDLE) && port_if.if_req && !grant_data;
    handshake   = (state == BUSY) && bus_valid_q && port_if.bus_ready;
    wd_en       = (state == BUSY) && bus_valid_q && !port_if.bus_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_fetch) state_nxt = BUSY;
      BUSY:    if (handshake || expire)       state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetches are always full-word reads.
  always_comb begin
    grant_req = '0;
    if (grant_data) begin
      grant_req.addr  = port_if.d_addr;
      grant_req.we    = port_if.d_we;
      grant_req.wdata = port_if.d_wdata;
      grant_req.be    = port_if.d_be;
    end else begin
      grant_req.addr  = port_if.if_addr;
      grant_req.be    = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_FETCH;
      streak      <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_data || grant_fetch) begin
        bus_q       <= grant_req;
        bus_valid_q <= 1'b1;
        owner       <= grant_data ? OWN_DATA : OWN_FETCH;
        if (grant_fetch)                        streak <= '0;
        else if (streak != SW'(MAX_DATA_STREAK)) streak <= streak + 1'b1;
      end else if (handshake) begin
        bus_valid_q <= 1'b0;
        resp_rdata  <= bus_q.we ? '0 : port_if.bus_rdata;
        resp_err    <= port_if.bus_err;
      end else if (expire) begin
        bus_valid_q <= 1'b0;
        resp_rdata  <= '0;
        resp_err    <= 1'b1;
      end
    end
  end

  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clr    (state != BUSY),
    .en     (wd_en),
    .expire (expire)
  );

  assign port_if.bus_valid = bus_valid_q;
  assign port_if.bus_addr  = bus_q.addr;
  assign port_if.bus_we    = bus_q.we;
  assign port_if.bus_wdata = bus_q.wdata;
  assign port_if.bus_be    = bus_q.be;

  assign port_if.if_done  = (state == RESP) && (owner == OWN_FETCH);
  assign port_if.d_done   = (state == RESP) && (owner == OWN_DATA);
  assign port_if.if_rdata = port_if.if_done ? resp_rdata : '0;
  assign port_if.d_rdata  = port_if.d_done  ? resp_rdata : '0;
  assign port_if.err      = (state == RESP) && resp_err;
  assign port_if.stall    = (port_if.if_req | port_if.d_req) & ~(port_if.if_done | port_if.d_done);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Per-cycle vector table for the basic flows, plus sequences for starvation and watchdog timeout.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8), .MAX_DATA_STREAK(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .port_if (bif)
  );

  typedef struct {
    logic rst_n, ifr; logic [31:0] ia; logic dr, dwe; logic [31:0] da, dwd; logic [3:0] dbe;
    logic rdy; logic [31:0] brd; logic berr;
    logic bv, ifd, dd, er, stl; logic [31:0] baddr; logic bwe; logic [31:0] bwd; logic [3:0] bbe;
    logic [31:0] ird, drd;
  } vec_t;

  vec_t tv[30];

  function automatic vec_t v(
    logic rst_n, logic ifr, logic [31:0] ia, logic dr, logic dwe, logic [31:0] da, logic [31:0] dwd,
    logic [3:0] dbe, logic rdy, logic [31:0] brd, logic berr,
    logic bv, logic ifd, logic dd, logic er, logic stl, logic [31:0] baddr, logic bwe,
    logic [31:0] bwd, logic [3:0] bbe, logic [31:0] ird, logic [31:0] drd);
    vec_t r;
    r.rst_n = rst_n; r.ifr = ifr; r.ia = ia; r.dr = dr; r.dwe = dwe; r.da = da; r.dwd = dwd;
    r.dbe = dbe; r.rdy = rdy; r.brd = brd; r.berr = berr;
    r.bv = bv; r.ifd = ifd; r.dd = dd; r.er = er; r.stl = stl; r.baddr = baddr; r.bwe = bwe;
    r.bwd = bwd; r.bbe = bbe; r.ird = ird; r.drd = drd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bif.if_req = 0; bif.if_addr = 0; bif.d_req = 0; bif.d_we = 0; bif.d_addr = 0;
    bif.d_wdata = 0; bif.d_be = 0; bif.bus_ready = 0; bif.bus_rdata = 0; bif.bus_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 0; drive_idle();
    @(posedge clock); #1;
    reset = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [5:0] order;
    int ndone, nbv;
    logic seen, err_at, bv_at;
    logic [31:0] rd_at;

    // rst ifr ia       dr we da       dwd         be    rdy brd          berr | bv ifd dd er stl baddr  bwe bwd         bbe  ird           drd
    tv[0]  = v(0,0,0,       0,0,0,      0,          0,    0,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);
    tv[1]  = v(1,1,'h100,   0,0,0,      0,          'hF,  1,'hDEADBEEF,  0,   0,0,0,0,1, 0,     0,0,          0,   0,            0);
    tv[2]  = v(1,1,'h100,   0,0,0,      0,          'hF,  1,'hDEADBEEF,  0,   1,0,0,0,1, 'h100, 0,0,          'hF, 0,            0);
    tv[3]  = v(1,1,'h100,   0,0,0,      0,          'hF,  1,'hDEADBEEF,  0,   0,1,0,0,0, 0,     0,0,          0,   'hDEADBEEF,   0);
    tv[4]  = v(1,0,0,       0,0,0,      0,          'hF,  1,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);
    tv[5]  = v(1,1,'h200,   1,0,'h300,  0,          'hF,  1,'h11112222,  0,   0,0,0,0,1, 0,     0,0,          0,   0,            0);
    tv[6]  = v(1,1,'h200,   1,0,'h300,  0,          'hF,  1,'h11112222,  0,   1,0,0,0,1, 'h300, 0,0,          'hF, 0,            0);
    tv[7]  = v(1,1,'h200,   1,0,'h300,  0,          'hF,  1,'h11112222,  0,   0,0,1,0,0, 0,     0,0,          0,   0,            'h11112222);
    tv[8]  = v(1,1,'h200,   0,0,0,      0,          'hF,  1,'h33334444,  0,   0,0,0,0,1, 0,     0,0,          0,   0,            0);
    tv[9]  = v(1,1,'h200,   0,0,0,      0,          'hF,  1,'h33334444,  0,   1,0,0,0,1, 'h200, 0,0,          'hF, 0,            0);
    tv[10] = v(1,1,'h200,   0,0,0,      0,          'hF,  1,'h33334444,  0,   0,1,0,0,0, 0,     0,0,          0,   'h33334444,   0);
    tv[11] = v(1,0,0,       0,0,0,      0,          'hF,  1,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);
    tv[12] = v(1,0,0,       1,0,'h40,   0,          'hF,  0,'hCAFEF00D,  0,   0,0,0,0,1, 0,     0,0,          0,   0,            0);
    tv[13] = v(1,0,0,       1,0,'h40,   0,          'hF,  0,'hCAFEF00D,  0,   1,0,0,0,1, 'h40,  0,0,          'hF, 0,            0);
    tv[14] = v(1,0,0,       1,0,'h40,   0,          'hF,  1,'hCAFEF00D,  0,   1,0,0,0,1, 'h40,  0,0,          'hF, 0,            0);
    tv[15] = v(1,0,0,       1,0,'h40,   0,          'hF,  1,'hCAFEF00D,  0,   0,0,1,0,0, 0,     0,0,          0,   0,            'hCAFEF00D);
    tv[16] = v(1,0,0,       0,0,0,      0,          'hF,  1,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);
    tv[17] = v(1,0,0,       1,1,'h80,   'hA5A5A5A5, 'h3,  1,'h12345678,  1,   0,0,0,0,1, 0,     0,0,          0,   0,            0);
    tv[18] = v(1,0,0,       1,1,'h80,   'hA5A5A5A5, 'h3,  1,'h12345678,  1,   1,0,0,0,1, 'h80,  1,'hA5A5A5A5, 'h3, 0,            0);
    tv[19] = v(1,0,0,       1,1,'h80,   'hA5A5A5A5, 'h3,  1,'h12345678,  1,   0,0,1,1,0, 0,     0,0,          0,   0,            0);
    tv[20] = v(1,0,0,       0,0,0,      0,          'hF,  1,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);
    tv[21] = v(1,0,0,       1,0,'hC0,   0,          'hF,  0,0,           0,   0,0,0,0,1, 0,     0,0,          0,   0,            0);
    tv[22] = v(1,0,0,       1,0,'hC0,   0,          'hF,  0,0,           0,   1,0,0,0,1, 'hC0,  0,0,          'hF, 0,            0);
    tv[23] = v(0,0,0,       1,0,'hC0,   0,          'hF,  0,0,           0,   1,0,0,0,1, 'hC0,  0,0,          'hF, 0,            0);
    tv[24] = v(1,0,0,       0,0,0,      0,          'hF,  0,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);
    tv[25] = v(1,0,0,       0,0,0,      0,          'hF,  0,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);
    tv[26] = v(1,0,0,       1,0,'hE0,   0,          'hF,  1,'h0BADF00D,  0,   0,0,0,0,1, 0,     0,0,          0,   0,            0);
    tv[27] = v(1,0,0,       1,0,'hE0,   0,          'hF,  1,'h0BADF00D,  0,   1,0,0,0,1, 'hE0,  0,0,          'hF, 0,            0);
    tv[28] = v(1,0,0,       1,0,'hE0,   0,          'hF,  1,'h0BADF00D,  0,   0,0,1,0,0, 0,     0,0,          0,   0,            'h0BADF00D);
    tv[29] = v(1,0,0,       0,0,0,      0,          'hF,  1,0,           0,   0,0,0,0,0, 0,     0,0,          0,   0,            0);

    reset = 0;
    drive_idle();
    repeat (2) @(posedge clock);

    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      reset = tv[i].rst_n;
      bif.if_req = tv[i].ifr; bif.if_addr = tv[i].ia; bif.d_req = tv[i].dr; bif.d_we = tv[i].dwe;
      bif.d_addr = tv[i].da; bif.d_wdata = tv[i].dwd; bif.d_be = tv[i].dbe;
      bif.bus_ready = tv[i].rdy; bif.bus_rdata = tv[i].brd; bif.bus_err = tv[i].berr;
      @(negedge clock);
      chk($sformatf("v%0d bus_valid", i), bif.bus_valid, tv[i].bv);
      chk($sformatf("v%0d if_done", i), bif.if_done, tv[i].ifd);
      chk($sformatf("v%0d d_done", i), bif.d_done, tv[i].dd);
      chk($sformatf("v%0d err", i), bif.err, tv[i].er);
      chk($sformatf("v%0d stall", i), bif.stall, tv[i].stl);
      chk($sformatf("v%0d if_rdata", i), bif.if_rdata, tv[i].ird);
      chk($sformatf("v%0d d_rdata", i), bif.d_rdata, tv[i].drd);
      if (tv[i].bv) begin
        chk($sformatf("v%0d bus_addr", i), bif.bus_addr, tv[i].baddr);
        chk($sformatf("v%0d bus_we", i), bif.bus_we, tv[i].bwe);
        chk($sformatf("v%0d bus_wdata", i), bif.bus_wdata, tv[i].bwd);
        chk($sformatf("v%0d bus_be", i), bif.bus_be, tv[i].bbe);
      end
    end

    // Both requesters held: four data grants, then fetch, then data again once the streak clears.
    do_reset();
    bif.d_req = 1; bif.d_addr = 'h1000; bif.d_be = 'hF; bif.if_req = 1; bif.if_addr = 'h2000;
    bif.bus_ready = 1; bif.bus_rdata = 'h55AA55AA;
    order = '0; ndone = 0;
    for (int c = 0; c < 60 && ndone < 6; c++) begin
      @(negedge clock);
      if (bif.d_done || bif.if_done) begin
        order = {order[4:0], bif.d_done};
        ndone++;
      end
    end
    chk("starve done_count", ndone, 6);
    chk("starve grant_order", order, 6'b111101);

    // Hung bus: bus_valid for exactly 8 cycles, then an error completion with zero data.
    do_reset();
    bif.d_req = 1; bif.d_addr = 'h500; bif.d_be = 'hF; bif.bus_ready = 0; bif.bus_rdata = 'hFFFFFFFF;
    nbv = 0; seen = 0; err_at = 0; rd_at = '1; bv_at = 1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock);
      if (bif.bus_valid) nbv++;
      if (bif.d_done) begin
        seen = 1; err_at = bif.err; rd_at = bif.d_rdata; bv_at = bif.bus_valid;
      end
    end
    chk("timeout done_seen", seen, 1);
    chk("timeout valid_cycles", nbv, 8);
    chk("timeout err", err_at, 1);
    chk("timeout d_rdata", rd_at, 0);
    chk("timeout bus_valid_at_done", bv_at, 0);
    @(posedge clock); #1;
    bif.d_req = 0;
    @(negedge clock);
    chk("timeout idle_after", {bif.bus_valid, bif.d_done, bif.err, bif.stall}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
